// File: rtl/adder_bcd_display_pkg.sv
// Shared types and constants for the BCD adder/display block:
// FSM state encoding, seven-segment codes and a digit-count helper.
package adder_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Number of decimal digits needed to show the largest (WIDTH+1)-bit value
    function automatic int required_digits(input int width);
        longint max_val;
        int     n;
        max_val = (longint'(1) << (width + 1)) - 1;
        n = 1;
        while (max_val >= 10) begin
            max_val = max_val / 10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/adder_bcd_display_if.sv
// Operand/control and result bus of the BCD adder/display block.
// The master drives operands and controls; the slave (the block) drives results.
interface adder_bcd_display_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
);
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                cin;
    logic                mode;
    logic                clear;
    logic                start;
    logic                busy;
    logic                done;
    logic [WIDTH:0]      sum;
    logic                overflow;
    logic [7*DIGITS-1:0] hex;

    modport master (
        output a, b, cin, mode, clear, start,
        input  busy, done, sum, overflow, hex
    );

    modport slave (
        input  a, b, cin, mode, clear, start,
        output busy, done, sum, overflow, hex
    );
endinterface

// File: rtl/adder_bcd_display_seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern; codes 10-15 and the
// blank flag both produce a dark digit.
module seg7_decoder
    import adder_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Table lookup, blank overrides the digit value
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/adder_bcd_display.sv
// Sequential adder/accumulator with iterative double-dabble conversion and a
// multi-digit seven-segment readout with leading-zero blanking.
module adder_bcd_display
    import adder_disp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_bcd_display_if.slave  bus
);

    localparam int RW = WIDTH + 1;        // result width
    localparam int BW = 4 * DIGITS;       // BCD field width
    localparam int CW = $clog2(RW + 1);   // shift counter width

    // Refuse to elaborate a display that cannot hold the largest result
    if (DIGITS < required_digits(WIDTH)) begin : g_digits_check
        $error("adder_bcd_display: DIGITS too small for WIDTH");
    end

    state_t              state_reg;
    logic [RW-1:0]       sum_reg;
    logic                overflow_reg;
    logic [RW-1:0]       shift_reg;
    logic [BW-1:0]       bcd_reg;
    logic [CW-1:0]       cnt_reg;
    logic [7*DIGITS-1:0] hex_reg;
    logic                busy_reg;
    logic                done_reg;

    // Both candidate results are formed every cycle; capture picks one
    logic [RW:0]         acc_total;
    logic [RW-1:0]       add_total;
    logic [RW-1:0]       capture_sum;

    assign acc_total = {1'b0, sum_reg} + {2'b00, bus.a} + {{RW{1'b0}}, bus.cin};
    assign add_total = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    assign capture_sum = bus.mode ? acc_total[RW-1:0] : add_total;

    // One double-dabble step: correct each nibble, then shift in the next bit
    logic [BW-1:0]       bcd_adj;
    logic [BW-1:0]       bcd_shift;
    logic [DIGITS-1:0]   digit_blank;
    logic [7*DIGITS-1:0] seg_next;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    (bcd_reg[4*gi +: 4] + 4'd3) :
                                    bcd_reg[4*gi +: 4];

        // A digit goes dark when it and every digit above it are zero;
        // the units digit is always lit so zero reads as "0".
        if (gi == 0) begin : g_units
            assign digit_blank[gi] = 1'b0;
        end else begin : g_upper
            assign digit_blank[gi] = ~(|bcd_shift[BW-1:4*gi]);
        end

        seg7_decoder u_dec (
            .bcd   (bcd_shift[4*gi +: 4]),
            .blank (digit_blank[gi]),
            .seg   (seg_next[7*gi +: 7])
        );
    end

    assign bcd_shift = {bcd_adj[BW-2:0], shift_reg[RW-1]};

    // Control FSM with accumulator, converter datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sum_reg      <= '0;
            overflow_reg <= 1'b0;
            shift_reg    <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                hex_reg[7*i +: 7] <= (i == 0) ? SEG_0 : SEG_BLANK;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.clear) begin
                        // clear wins over a simultaneous start
                        sum_reg      <= '0;
                        overflow_reg <= 1'b0;
                    end else if (bus.start) begin
                        sum_reg   <= capture_sum;
                        shift_reg <= capture_sum;
                        bcd_reg   <= '0;
                        cnt_reg   <= CW'(RW);
                        busy_reg  <= 1'b1;
                        state_reg <= CONV;
                        if (bus.mode && acc_total[RW]) begin
                            overflow_reg <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    bcd_reg   <= bcd_shift;
                    shift_reg <= {shift_reg[RW-2:0], 1'b0};
                    cnt_reg   <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        hex_reg   <= seg_next;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.sum      = sum_reg;
    assign bus.overflow = overflow_reg;
    assign bus.hex      = hex_reg;

endmodule
